// File: rtl/ram_port_arbiter.sv
// Arbitrates NCH requesters onto a single MMU port. Partial-word writes are
// turned into a read-modify-write sequence; responses return on a one-cycle ack.
module ram_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NCH      = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            req_i,
  input  logic [NCH-1:0]            we_i,
  input  logic [NCH*(DATA_W/8)-1:0] sel_i,
  input  logic [NCH*ADDR_W-1:0]     addr_i,
  input  logic [NCH*DATA_W-1:0]     wdata_i,
  output logic [NCH-1:0]            ack_o,
  output logic [NCH*DATA_W-1:0]     rdata_o,
  output logic [NCH-1:0]            tlb_err_o,
  output logic [NCH-1:0]            tlb_mod_o,
  output logic                      ce_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         data_o,
  input  logic                      ready_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      tlb_err_i,
  input  logic                      mod_i
);
  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  gnt;
  logic [IDX_W-1:0]  last_grant;
  logic              rmw;
  logic              aborted;
  logic              mask_valid;
  logic [SEL_W-1:0]  lat_sel;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] merged;
  logic [NCH-1:0]    eligible;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  idx;
  logic              pick_valid;
  logic              live;
  logic [NCH-1:0]    gnt_hot;
  logic [SEL_W-1:0]  pick_sel;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  assign pick_sel   = sel_i[pick*SEL_W +: SEL_W];
  assign pick_addr  = addr_i[pick*ADDR_W +: ADDR_W];
  assign pick_wdata = wdata_i[pick*DATA_W +: DATA_W];
  assign live       = req_i[gnt] && !aborted;

  always_comb begin
    gnt_hot      = '0;
    gnt_hot[gnt] = 1'b1;
    eligible     = req_i;
    if (mask_valid) eligible[gnt] = 1'b0;
  end

  // Walk from lowest to highest priority so the last eligible hit wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (ARB_MODE == 1) ? IDX_W'(i - 1) : IDX_W'((int'(last_grant) + i) % NCH);
      if (eligible[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    merged = rd_buf;
    for (int b = 0; b < SEL_W; b++)
      if (lat_sel[b]) merged[b*8 +: 8] = lat_wdata[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NCH - 1);
      gnt        <= '0;
      rmw        <= 1'b0;
      aborted    <= 1'b0;
      mask_valid <= 1'b0;
      lat_sel    <= '0;
      lat_wdata  <= '0;
      rd_buf     <= '0;
      ack_o      <= '0;
      rdata_o    <= '0;
      tlb_err_o  <= '0;
      tlb_mod_o  <= '0;
      ce_o       <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
    end else begin
      ack_o     <= '0;
      tlb_err_o <= '0;
      tlb_mod_o <= '0;
      case (state)
        IDLE: begin
          mask_valid <= 1'b0;
          if (pick_valid) begin
            gnt        <= pick;
            last_grant <= pick;
            lat_sel    <= pick_sel;
            lat_wdata  <= pick_wdata;
            aborted    <= 1'b0;
            rmw        <= 1'b0;
            addr_o     <= pick_addr;
            if (!we_i[pick]) begin
              state <= RD;
              ce_o  <= 1'b1;
              we_o  <= 1'b0;
            end else if (&pick_sel) begin
              state  <= WR;
              ce_o   <= 1'b1;
              we_o   <= 1'b1;
              data_o <= pick_wdata;
            end else if (|pick_sel) begin
              state <= RD;
              rmw   <= 1'b1;
              ce_o  <= 1'b1;
              we_o  <= 1'b0;
            end else begin
              state       <= DONE;
              ack_o       <= '0;
              ack_o[pick] <= 1'b1;
            end
          end
        end
        RD: begin
          if (!req_i[gnt]) aborted <= 1'b1;
          if (ready_i) begin
            ce_o   <= 1'b0;
            rd_buf <= data_i;
            if (rmw && !tlb_err_i && live) begin
              state <= MERGE;
            end else begin
              state <= DONE;
              if (live) begin
                ack_o     <= gnt_hot;
                tlb_err_o <= tlb_err_i ? gnt_hot : '0;
                if (!rmw) rdata_o[gnt*DATA_W +: DATA_W] <= data_i;
              end
            end
          end
        end
        MERGE: begin
          rd_buf <= merged;
          if (live) begin
            state  <= WR;
            ce_o   <= 1'b1;
            we_o   <= 1'b1;
            data_o <= merged;
          end else begin
            state <= DONE;
          end
        end
        WR: begin
          if (!req_i[gnt]) aborted <= 1'b1;
          if (ready_i) begin
            ce_o  <= 1'b0;
            we_o  <= 1'b0;
            state <= DONE;
            if (live) begin
              ack_o     <= gnt_hot;
              tlb_err_o <= tlb_err_i ? gnt_hot : '0;
              tlb_mod_o <= mod_i ? gnt_hot : '0;
            end
          end
        end
        DONE: begin
          mask_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a vector table of single transactions against a
// behavioural MMU, plus hand sequences for arbitration, aborts and reset.
module tb_ram_port_arbiter;
  localparam int DW = 32, AW = 32, NCH = 2, SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NCH-1:0]    req_i = '0, we_i = '0;
  logic [NCH*SW-1:0] sel_i = '0;
  logic [NCH*AW-1:0] addr_i = '0;
  logic [NCH*DW-1:0] wdata_i = '0;
  logic [NCH-1:0]    ack_o, tlb_err_o, tlb_mod_o;
  logic [NCH*DW-1:0] rdata_o;
  logic              ce_o, we_o;
  logic [AW-1:0]     addr_o;
  logic [DW-1:0]     data_o;
  logic              ready_i = 1'b0, tlb_err_i = 1'b0, mod_i = 1'b0;
  logic [DW-1:0]     data_i = '0;

  logic [NCH-1:0]    req_fp = '0;
  logic [NCH-1:0]    ack_fp, err_fp, mod_fp;
  logic [NCH*DW-1:0] rdata_fp;
  logic              ce_fp, we_fp, ready_fp;
  logic [AW-1:0]     addr_fp;
  logic [DW-1:0]     data_fp;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NCH(NCH), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .tlb_err_o(tlb_err_o), .tlb_mod_o(tlb_mod_o), .ce_o(ce_o), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .ready_i(ready_i), .data_i(data_i),
    .tlb_err_i(tlb_err_i), .mod_i(mod_i)
  );

  // Fixed-priority instance with a zero-wait responder.
  assign ready_fp = ce_fp;
  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NCH(NCH), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .req_i(req_fp), .we_i(2'b00), .sel_i(8'hFF),
    .addr_i(64'h0), .wdata_i(64'h0), .ack_o(ack_fp), .rdata_o(rdata_fp),
    .tlb_err_o(err_fp), .tlb_mod_o(mod_fp), .ce_o(ce_fp), .we_o(we_fp),
    .addr_o(addr_fp), .data_o(data_fp), .ready_i(ready_fp), .data_i(32'h0F0F0F0F),
    .tlb_err_i(1'b0), .mod_i(1'b0)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  int   mmu_wait = 0, wait_cnt = 0;
  logic mmu_err = 1'b0, mmu_mod = 1'b0;

  // Behavioural MMU: ready after mmu_wait extra ce cycles; faulting writes are dropped.
  always @(negedge clk) begin
    if (ce_o && !ready_i && wait_cnt >= mmu_wait) begin
      ready_i   = 1'b1;
      tlb_err_i = mmu_err;
      mod_i     = mmu_mod;
      data_i    = mem[addr_o[5:2]];
      if (we_o && !mmu_err && !mmu_mod) mem[addr_o[5:2]] = data_o;
      wait_cnt  = 0;
    end else begin
      ready_i   = 1'b0;
      tlb_err_i = 1'b0;
      mod_i     = 1'b0;
      wait_cnt  = ce_o ? wait_cnt + 1 : 0;
    end
  end

  int ce_cycles = 0, we_cycles = 0, ack_pulses = 0, multi_ack = 0;
  always @(negedge clk) begin
    if (ce_o) ce_cycles++;
    if (we_o) we_cycles++;
    if (ack_o != '0) ack_pulses++;
    if (!$onehot0(ack_o)) multi_ack++;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  typedef struct {
    int ch; logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata;
    int wt; logic terr; logic tmod;
    int lat; logic [31:0] rd0; logic [31:0] rd1; logic eerr; logic emod;
    int ce_n; int we_n; int midx; logic [31:0] emem;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_ack(output logic [NCH-1:0] a, output int cyc);
    a = '0; cyc = 0;
    while (a == '0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      a = ack_o;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int lat, ce0, we0;
    logic [NCH-1:0] a, exp_ack;
    mmu_wait = v.wt; mmu_err = v.terr; mmu_mod = v.tmod;
    exp_ack = '0; exp_ack[v.ch] = 1'b1;
    ce0 = ce_cycles; we0 = we_cycles;
    @(negedge clk);
    we_i[v.ch] = v.we;
    sel_i[v.ch*SW +: SW] = v.sel;
    addr_i[v.ch*AW +: AW] = v.addr;
    wdata_i[v.ch*DW +: DW] = v.wdata;
    req_i[v.ch] = 1'b1;
    wait_ack(a, lat);
    check_output("latency", lat, v.lat);
    check_output("ack_o", a, exp_ack);
    check_output("tlb_err_o", tlb_err_o, v.eerr ? exp_ack : '0);
    check_output("tlb_mod_o", tlb_mod_o, v.emod ? exp_ack : '0);
    check_output("rdata_ch0", rdata_o[31:0], v.rd0);
    check_output("rdata_ch1", rdata_o[63:32], v.rd1);
    @(negedge clk);
    req_i[v.ch] = 1'b0;
    check_output("ce_cycles", ce_cycles - ce0, v.ce_n);
    check_output("we_cycles", we_cycles - we0, v.we_n);
    @(posedge clk); #1;
    check_output("ack_one_cycle", ack_o, '0);
    check_output("mem_word", mem[v.midx], v.emem);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [NCH-1:0] a, order[4];
    int cyc, n, ap0, ce0;

    vecs[0] = '{ch:1, we:0, sel:4'hF, addr:32'h100, wdata:0, wt:2, terr:0, tmod:0,
                lat:4, rd0:0, rd1:32'hDEADBEEF, eerr:0, emod:0, ce_n:3, we_n:0, midx:0, emem:32'hDEADBEEF};
    vecs[1] = '{ch:0, we:1, sel:4'b0101, addr:32'h104, wdata:32'hAABBCCDD, wt:0, terr:0, tmod:0,
                lat:4, rd0:0, rd1:32'hDEADBEEF, eerr:0, emod:0, ce_n:2, we_n:1, midx:1, emem:32'h11BB33DD};
    vecs[2] = '{ch:0, we:0, sel:4'hF, addr:32'h104, wdata:0, wt:0, terr:0, tmod:0,
                lat:2, rd0:32'h11BB33DD, rd1:32'hDEADBEEF, eerr:0, emod:0, ce_n:1, we_n:0, midx:1, emem:32'h11BB33DD};
    vecs[3] = '{ch:1, we:1, sel:4'hF, addr:32'h108, wdata:32'h0BADF00D, wt:1, terr:0, tmod:0,
                lat:3, rd0:32'h11BB33DD, rd1:32'hDEADBEEF, eerr:0, emod:0, ce_n:2, we_n:2, midx:2, emem:32'h0BADF00D};
    vecs[4] = '{ch:1, we:1, sel:4'hF, addr:32'h10C, wdata:32'h12345678, wt:0, terr:0, tmod:1,
                lat:2, rd0:32'h11BB33DD, rd1:32'hDEADBEEF, eerr:0, emod:1, ce_n:1, we_n:1, midx:3, emem:32'hCAFEF00D};
    vecs[5] = '{ch:0, we:1, sel:4'b0011, addr:32'h110, wdata:32'hFFFFFFFF, wt:0, terr:1, tmod:0,
                lat:2, rd0:32'h11BB33DD, rd1:32'hDEADBEEF, eerr:1, emod:0, ce_n:1, we_n:0, midx:4, emem:32'h44444444};
    vecs[6] = '{ch:1, we:1, sel:4'b0000, addr:32'h114, wdata:32'h77777777, wt:0, terr:1, tmod:1,
                lat:1, rd0:32'h11BB33DD, rd1:32'hDEADBEEF, eerr:0, emod:0, ce_n:0, we_n:0, midx:5, emem:32'h0};
    vecs[7] = '{ch:1, we:0, sel:4'hF, addr:32'h118, wdata:0, wt:1, terr:1, tmod:1,
                lat:3, rd0:32'h11BB33DD, rd1:32'h66666666, eerr:1, emod:0, ce_n:2, we_n:0, midx:6, emem:32'h66666666};
    vecs[8] = '{ch:0, we:1, sel:4'hF, addr:32'h124, wdata:32'h0, wt:0, terr:1, tmod:0,
                lat:2, rd0:32'h11BB33DD, rd1:32'h66666666, eerr:1, emod:0, ce_n:1, we_n:1, midx:9, emem:32'h99999999};
    vecs[9] = '{ch:0, we:1, sel:4'b1000, addr:32'h11C, wdata:32'h5A000000, wt:1, terr:0, tmod:0,
                lat:6, rd0:32'h11BB33DD, rd1:32'h66666666, eerr:0, emod:0, ce_n:4, we_n:2, midx:7, emem:32'h5AFEBABE};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h11223344; mem[3] = 32'hCAFEF00D;
    mem[4] = 32'h44444444; mem[6] = 32'h66666666; mem[7] = 32'hCAFEBABE;
    mem[9] = 32'h99999999; mem[10] = 32'hA0A0A0A0;

    repeat (3) @(negedge clk);
    check_output("reset_ctrl", {ce_o, we_o, ack_o, tlb_err_o, tlb_mod_o}, '0);
    check_output("reset_addr", addr_o, '0);
    check_output("reset_data", data_o, '0);
    check_output("reset_rdata", rdata_o, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

    // Request withdrawn mid-read: access completes, no ack, rdata untouched.
    mmu_wait = 3; mmu_err = 0; mmu_mod = 0;
    ap0 = ack_pulses; ce0 = ce_cycles;
    @(negedge clk);
    we_i[1] = 1'b0; addr_i[AW +: AW] = 32'h100; req_i[1] = 1'b1;
    repeat (2) @(negedge clk);
    req_i[1] = 1'b0;
    check_output("abort_ce_held", ce_o, 1'b1);
    cyc = 0;
    while (ce_o && cyc < 20) begin @(negedge clk); cyc++; end
    check_output("abort_ce_dropped", ce_o, 1'b0);
    repeat (4) @(negedge clk);
    check_output("abort_ce_cycles", ce_cycles - ce0, 4);
    check_output("abort_no_ack", ack_pulses - ap0, 0);
    check_output("abort_rdata", rdata_o[63:32], 32'h66666666);

    // Reset while the write phase is waiting on the MMU.
    mmu_wait = 5;
    @(negedge clk);
    we_i[0] = 1'b1; sel_i[3:0] = 4'hF; addr_i[31:0] = 32'h128; wdata_i[31:0] = 32'h12345678;
    req_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_pre_we", {ce_o, we_o}, 2'b11);
    rst = 1'b0;
    #1;
    check_output("rst_ctrl", {ce_o, we_o, ack_o, tlb_err_o, tlb_mod_o}, '0);
    check_output("rst_addr", addr_o, '0);
    check_output("rst_data", data_o, '0);
    check_output("rst_rdata", rdata_o, '0);
    @(negedge clk);
    req_i = '0; we_i = '0;
    @(negedge clk);
    rst = 1'b1;
    ap0 = ack_pulses;
    repeat (8) @(negedge clk);
    check_output("rst_no_ack", ack_pulses - ap0, 0);
    check_output("rst_mem", mem[10], 32'hA0A0A0A0);

    // Round-robin with both channels requesting continuously.
    mmu_wait = 0;
    addr_i[31:0] = 32'h100; addr_i[63:32] = 32'h104;
    req_i = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (ack_o != '0) begin order[n] = ack_o; n++; end
    end
    @(negedge clk);
    req_i = '0;
    check_output("rr_count", n, 4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("rr_grant%0d", i), (i < n) ? order[i] : 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);
    check_output("rr_rdata0", rdata_o[31:0], 32'hDEADBEEF);
    check_output("rr_rdata1", rdata_o[63:32], 32'h11BB33DD);

    // After ch0 is served, round-robin favours ch1 on contention.
    repeat (3) @(negedge clk);
    req_i = 2'b01;
    wait_ack(a, cyc);
    check_output("rr_solo_ack", a, 2'b01);
    @(negedge clk); req_i = '0;
    repeat (3) @(negedge clk);
    req_i = 2'b11;
    wait_ack(a, cyc);
    check_output("rr_contend", a, 2'b10);
    @(negedge clk); req_i = '0;
    repeat (3) @(negedge clk);

    // Fixed priority: the same pattern must keep choosing ch0.
    req_fp = 2'b01;
    a = '0; cyc = 0;
    while (a == '0 && cyc < 40) begin @(posedge clk); #1; cyc++; a = ack_fp; end
    check_output("fp_solo_ack", a, 2'b01);
    check_output("fp_rdata0", rdata_fp[31:0], 32'h0F0F0F0F);
    @(negedge clk); req_fp = '0;
    repeat (3) @(negedge clk);
    req_fp = 2'b11;
    a = '0; cyc = 0;
    while (a == '0 && cyc < 40) begin @(posedge clk); #1; cyc++; a = ack_fp; end
    check_output("fp_contend", a, 2'b01);
    @(negedge clk); req_fp = '0;
    repeat (3) @(negedge clk);

    check_output("multi_ack", multi_ack, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised memory port arbiter and byte-lane adapter between NCH CPU-side requesters (instruction fetch, load/store, and future DMA or second-core ports) and the single MMU port. Each granted request becomes one MMU access sequence: a read, a full-word write, or a partial write done as read-modify-write. Responses return on a one-cycle ack. It is the multi-channel, width-generic successor to the single fetch/data RAM adapter.

## Interface
- DATA_W, 32: data width; multiple of 8; SEL_W = DATA_W/8.
- ADDR_W, 32: address width.
- NCH, 2: number of requester channels (1..8); channel 0 = instruction fetch.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NCH  per-channel request level.
- we_i  in  NCH  per-channel write enable.
- sel_i  in  NCH*SEL_W  per-channel byte enables; channel c at [c*SEL_W +: SEL_W].
- addr_i  in  NCH*ADDR_W  per-channel address.
- wdata_i  in  NCH*DATA_W  per-channel write data.
- ack_o  out  NCH  one-cycle completion pulse per channel.
- rdata_o  out  NCH*DATA_W  per-channel read data; held until that channel's next read ack.
- tlb_err_o  out  NCH  TLB miss flag; valid with ack.
- tlb_mod_o  out  NCH  TLB modify fault flag; valid with a write ack.
- ce_o, we_o  out  1 each  MMU chip enable / write op (1 = write).
- addr_o  out  ADDR_W  MMU address.
- data_o  out  DATA_W  MMU write data.
- ready_i  in  1  MMU access complete; sampled only while ce_o = 1.
- data_i  in  DATA_W  MMU read data; valid with ready_i.
- tlb_err_i, mod_i  in  1 each  MMU fault flags; valid with ready_i.

## Operation
- FSM states: IDLE, RD, MERGE, WR, DONE.
- IDLE: if any eligible req_i is high, latch the granted channel g and its we, sel, addr and wdata.
  - we = 0 goes to RD.
  - we = 1 with sel all ones goes to WR.
  - we = 1 with sel partial goes to RD, then RMW.
  - we = 1 with sel = 0 goes to DONE with no MMU access.
- RD: ce_o = 1, we_o = 0, addr_o = latched addr. On ready_i, capture data_i and tlb_err_i.
  - Plain read goes to DONE.
  - RMW read goes to MERGE; if tlb_err_i is set it goes to DONE and the write is skipped.
- MERGE: for each byte lane b, buffer[b] = sel[b] ? wdata[b] : read data[b]. Then go to WR.
- WR: ce_o = 1, we_o = 1, data_o = full wdata or the merged buffer. On ready_i, capture tlb_err_i and mod_i, then go to DONE.
- DONE: ack_o[g] = 1 for one cycle. On a read, rdata_o[g] is updated in the same cycle. Then go to IDLE.
- Arbitration, ARB_MODE = 0: search starts at (last_grant+1) mod NCH. ARB_MODE = 1: lowest index wins.
- Eligibility: in the IDLE cycle directly after DONE, the just-acked channel is masked. A req still high one cycle after its ack is therefore not re-granted; if it is still high two cycles after the ack, it is a new request.
- Requesters hold req and all fields stable until ack. If req drops mid-sequence, the MMU access in flight completes, ack is suppressed, and rdata_o is unchanged.
- tlb_err_o and tlb_mod_o for writes without RMW come from the WR phase only. Both flags are 0 for sel = 0.

## Timing
- Reset (rst = 0, asynchronous):
  - FSM goes to IDLE and last_grant to NCH-1.
  - Outputs clear: ce_o, we_o, ack_o, tlb flags, addr_o, data_o and rdata_o are all 0.
  - An in-flight MMU access is abandoned and no ack is issued.
- Request high at edge T (in IDLE) means ce_o = 1 from T+1.
- Read: ready_i at cycle T+k (k ≥ 1) gives ack at T+k+1. Minimum latency is 2 cycles.
- Full write: same as read, minimum 2 cycles.
- RMW: read ready at T+k, MERGE at T+k+1, WR ce_o from T+k+2, write ready at T+k+1+m, ack one cycle later. Minimum latency is 4 cycles.
- sel = 0 write: ack at T+1; ce_o never asserted.
- ce_o drops in the cycle after ready_i. ready_i seen while ce_o = 0 is ignored.
- Throughput: one idle cycle between transactions.
- At most one ack_o bit is set per cycle.

## Test plan
- Single read, NCH = 2: ch1 reads 0x100 with ready_i after 3 cycles and data_i = 0xDEADBEEF. Required: ack_o = 2'b10 exactly once, rdata_o[ch1] = 0xDEADBEEF, ch0 rdata_o unchanged.
- Partial write: memory holds 0x11223344; write sel = 4'b0101, wdata = 0xAABBCCDD. Required: MMU read, then MMU write of 0x11BB33DD, then ack. Latency is 4 cycles with zero-wait ready.
- Round-robin: ch0 and ch1 both hold continuous read requests. Required: grants alternate 0,1,0,1 over 4 transactions and neither channel waits more than one transaction. With ARB_MODE = 1, ch0 wins each contention.
- RMW TLB abort: tlb_err_i = 1 on the read phase of a sel = 4'b0011 write. Required: no write cycle (we_o stays 0), ack with tlb_err_o = 1.
- sel = 0 write: required ack at T+1, ce_o never high.
- Abort on req drop: req drops mid-RD. Required: ce_o held until ready_i, no ack, rdata_o unchanged.
- Reset mid-WR: required: all outputs 0 at once, no ack after release, next request handled normally.
